// File: rtl/cavlc_level_collector_if.sv
`default_nettype none
// cavlc_level_collector_if: valid/ready coefficient stream into the CAVLC level collector.
interface cavlc_level_collector_if #(
  parameter int COEFF_W = 8
);
  logic               coeff_valid_i;
  logic               coeff_ready_o;
  logic [COEFF_W-1:0] coeff_i;
  logic               coeff_last_i;

  modport master (
    output coeff_valid_i,
    output coeff_i,
    output coeff_last_i,
    input  coeff_ready_o
  );

  modport slave (
    input  coeff_valid_i,
    input  coeff_i,
    input  coeff_last_i,
    output coeff_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/cavlc_level_collector.sv
`default_nettype none
// cavlc_level_collector: TotalCoeff / TrailingOnes / T1 signs and level list for one CAVLC block.
// Macro CAVLC_LEVEL_CODE_EN: list holds unsigned levelCode instead of raw signed coefficients.
module cavlc_level_collector #(
  parameter int COEFF_W    = 8,
  parameter int MAX_COEFFS = 16,
  parameter int CNT_W      = $clog2(MAX_COEFFS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blk_start_i,
  cavlc_level_collector_if.slave coeff_if,
  output logic [CNT_W-1:0]    total_coeff_o,
  output logic [1:0]          trailing_ones_o,
  output logic [2:0]          t1_signs_o,
  output logic [CNT_W-1:0]    level_cnt_o,
  input  logic [CNT_W-1:0]    rd_idx_i,
  output logic [COEFF_W-1:0]  rd_level_o,
  output logic                blk_done_o,
  output logic                overflow_o
);

  localparam int IDX_W = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COEFFS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic               ready;
  logic               done;
  logic [CNT_W-1:0]   total_coeff;
  logic [1:0]         trailing_ones;
  logic [2:0]         t1_signs;
  logic [CNT_W-1:0]   level_cnt;
  logic               seen_level;
  logic               overflow;
  logic [COEFF_W-1:0] list [MAX_COEFFS];

  logic               neg;
  logic               nonzero;
  logic [COEFF_W:0]   coeff_sx;
  logic [COEFF_W:0]   abs_c;
  logic               is_t1;
  logic               t1_phase;
  logic [COEFF_W-1:0] entry;

  // One extra bit so that |-2^(COEFF_W-1)| is representable.
  always_comb begin
    neg      = coeff_if.coeff_i[COEFF_W-1];
    nonzero  = (coeff_if.coeff_i != '0);
    coeff_sx = {coeff_if.coeff_i[COEFF_W-1], coeff_if.coeff_i};
    abs_c    = neg ? (~coeff_sx + 1'b1) : coeff_sx;
    is_t1    = (abs_c == {{COEFF_W{1'b0}}, 1'b1});
    t1_phase = (trailing_ones < 2'd3) && !seen_level;
  end

`ifdef CAVLC_LEVEL_CODE_EN
  logic [COEFF_W+1:0] level_code;

  always_comb begin
    level_code = {1'b0, abs_c, 1'b0} - {{COEFF_W{1'b0}}, ~neg, neg};
    if ((trailing_ones < 2'd3) && (level_cnt == '0)) begin
      level_code = level_code - {{COEFF_W{1'b0}}, 2'd2};
    end
    entry = level_code[COEFF_W-1:0];
  end
`else
  always_comb begin
    entry = coeff_if.coeff_i;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ready         <= 1'b0;
      done          <= 1'b0;
      total_coeff   <= '0;
      trailing_ones <= '0;
      t1_signs      <= '0;
      level_cnt     <= '0;
      seen_level    <= 1'b0;
      overflow      <= 1'b0;
      for (int i = 0; i < MAX_COEFFS; i++) list[i] <= '0;
    end else if (blk_start_i) begin
      // A restart wins over any coefficient handshaken in the same cycle.
      state         <= COLLECT;
      ready         <= 1'b1;
      done          <= 1'b0;
      total_coeff   <= '0;
      trailing_ones <= '0;
      t1_signs      <= '0;
      level_cnt     <= '0;
      seen_level    <= 1'b0;
      overflow      <= 1'b0;
      for (int i = 0; i < MAX_COEFFS; i++) list[i] <= '0;
    end else if ((state == COLLECT) && coeff_if.coeff_valid_i) begin
      if (nonzero) begin
        if (total_coeff != MAX_CNT) total_coeff <= total_coeff + 1'b1;
        if (t1_phase && is_t1) begin
          t1_signs[trailing_ones] <= neg;
          trailing_ones           <= trailing_ones + 1'b1;
        end else begin
          seen_level <= 1'b1;
          if (level_cnt != MAX_CNT) begin
            list[level_cnt[IDX_W-1:0]] <= entry;
            level_cnt                  <= level_cnt + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
      if (coeff_if.coeff_last_i) begin
        state <= DONE;
        ready <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  assign coeff_if.coeff_ready_o = ready;
  assign total_coeff_o          = total_coeff;
  assign trailing_ones_o        = trailing_ones;
  assign t1_signs_o             = t1_signs;
  assign level_cnt_o            = level_cnt;
  assign blk_done_o             = done;
  assign overflow_o             = overflow;
  assign rd_level_o             = (rd_idx_i < level_cnt) ? list[rd_idx_i[IDX_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_level_collector.sv
`default_nettype none
// tb_cavlc_level_collector: scoreboard bench driving a 16-deep and a 4-deep collector in parallel.
module tb_cavlc_level_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [7:0] coeff = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic       sel = 1'b0;

  int checks = 0;
  int errors = 0;
  int blocks_done = 0;
  int blocks_exp = 0;

  always #5 clk = ~clk;

  cavlc_level_collector_if #(.COEFF_W(8)) bus16 ();
  cavlc_level_collector_if #(.COEFF_W(8)) bus4 ();

  assign bus16.coeff_valid_i = valid;
  assign bus16.coeff_i       = coeff;
  assign bus16.coeff_last_i  = last;
  assign bus4.coeff_valid_i  = valid;
  assign bus4.coeff_i        = coeff;
  assign bus4.coeff_last_i   = last;

  logic [4:0] tot16, lc16;
  logic [2:0] tot4, lc4;
  logic [1:0] t1_16, t1_4;
  logic [2:0] sg16, sg4;
  logic [7:0] rl16, rl4;
  logic       dn16, dn4, ov16, ov4;

  cavlc_level_collector #(.COEFF_W(8), .MAX_COEFFS(16)) dut16 (
    .clk(clk), .rst(rst), .blk_start_i(start), .coeff_if(bus16.slave),
    .total_coeff_o(tot16), .trailing_ones_o(t1_16), .t1_signs_o(sg16),
    .level_cnt_o(lc16), .rd_idx_i(rd_idx), .rd_level_o(rl16),
    .blk_done_o(dn16), .overflow_o(ov16)
  );

  cavlc_level_collector #(.COEFF_W(8), .MAX_COEFFS(4)) dut4 (
    .clk(clk), .rst(rst), .blk_start_i(start), .coeff_if(bus4.slave),
    .total_coeff_o(tot4), .trailing_ones_o(t1_4), .t1_signs_o(sg4),
    .level_cnt_o(lc4), .rd_idx_i(rd_idx[2:0]), .rd_level_o(rl4),
    .blk_done_o(dn4), .overflow_o(ov4)
  );

  wire [4:0] m_tot = sel ? {2'b00, tot4} : tot16;
  wire [4:0] m_lc  = sel ? {2'b00, lc4} : lc16;
  wire [1:0] m_t1  = sel ? t1_4 : t1_16;
  wire [2:0] m_sg  = sel ? sg4 : sg16;
  wire [7:0] m_rl  = sel ? rl4 : rl16;
  wire       m_dn  = sel ? dn4 : dn16;
  wire       m_ov  = sel ? ov4 : ov16;
  wire       m_rdy = sel ? bus4.coeff_ready_o : bus16.coeff_ready_o;

  typedef struct packed {
    logic [4:0]       tot;
    logic [1:0]       t1;
    logic [2:0]       sg;
    logic [4:0]       lc;
    logic             ovf;
    logic [15:0][7:0] lst;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic expect_blk(input logic [4:0] tot, input logic [1:0] t1, input logic [2:0] sg,
                            input logic [4:0] lc, input logic ovf,
                            input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3);
    exp_t e;
    e        = '0;
    e.tot    = tot;
    e.t1     = t1;
    e.sg     = sg;
    e.lc     = lc;
    e.ovf    = ovf;
    e.lst[0] = l0;
    e.lst[1] = l1;
    e.lst[2] = l2;
    e.lst[3] = l3;
    q.push_back(e);
    blocks_exp++;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    valid = 1'b1;
    coeff = c;
    last  = l;
    while (!m_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_rdy) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_blk();
    int n;
    n = 0;
    while (blocks_done < blocks_exp && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (blocks_done < blocks_exp) chk("block_timeout", blocks_done, blocks_exp);
  endtask

  // Monitor: on each rising blk_done of the selected DUT, pop and compare everything.
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_dn && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("total_coeff", m_tot, e.tot);
          chk("trailing_ones", m_t1, e.t1);
          chk("t1_signs", m_sg, e.sg);
          chk("level_cnt", m_lc, e.lc);
          chk("overflow", m_ov, e.ovf);
          for (int i = 0; i <= int'(e.lc) && i < 17; i++) begin
            rd_idx = 5'(i);
            #1;
            chk($sformatf("rd_level[%0d]", i), m_rl, (i < int'(e.lc)) ? e.lst[i] : 8'h00);
          end
          rd_idx = 5'd0;
        end
        blocks_done++;
      end
      prev = m_dn;
    end
  end

  initial begin
    #3;
    chk("reset_total", m_tot, 0);
    chk("reset_ready", m_rdy, 0);
    chk("reset_done", m_dn, 0);
    chk("reset_overflow", m_ov, 0);
    chk("reset_rd_level", m_rl, 0);
    @(negedge clk);
    rst = 1'b1;

    // Coefficients offered in IDLE are not accepted.
    @(negedge clk);
    valid = 1'b1; coeff = 8'h05; last = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", m_rdy, 0);
    chk("idle_done", m_dn, 0);
    chk("idle_total", m_tot, 0);
    valid = 1'b0; last = 1'b0;

    // 0,0,1,-1,1,1,-3,2
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(6, 3, 3'b010, 3, 0, 8'd0, 8'd5, 8'd2, 8'd0);
`else
    expect_blk(6, 3, 3'b010, 3, 0, 8'h01, 8'hFD, 8'h02, 8'h00);
`endif
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0);
    send(8'h01, 0); send(8'h01, 0); send(8'hFD, 0); send(8'h02, 1);
    wait_blk();

    // 0,1,5,-1 ; rd_idx 2 reads 0
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(3, 1, 3'b000, 2, 0, 8'd6, 8'd1, 8'd0, 8'd0);
`else
    expect_blk(3, 1, 3'b000, 2, 0, 8'h05, 8'hFF, 8'h00, 8'h00);
`endif
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h05, 0); send(8'hFF, 1);
    wait_blk();

    // Most negative coefficient as a level
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(1, 0, 3'b000, 1, 0, 8'hFD, 8'h00, 8'h00, 8'h00);
`else
    expect_blk(1, 0, 3'b000, 1, 0, 8'h80, 8'h00, 8'h00, 8'h00);
`endif
    pulse_start();
    send(8'h80, 1);
    wait_blk();

    // 1,3,-1,1 : a non-T1 level ends the T1 phase early
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(4, 1, 3'b000, 3, 0, 8'd2, 8'd1, 8'd0, 8'd0);
`else
    expect_blk(4, 1, 3'b000, 3, 0, 8'h03, 8'hFF, 8'h01, 8'h00);
`endif
    pulse_start();
    send(8'h01, 0); send(8'h03, 0); send(8'hFF, 0); send(8'h01, 1);
    wait_blk();

    // 4-deep instance: 2,2,2,2,2 overflows
    sel = 1'b1;
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(4, 0, 3'b000, 4, 1, 8'd0, 8'd2, 8'd2, 8'd2);
`else
    expect_blk(4, 0, 3'b000, 4, 1, 8'h02, 8'h02, 8'h02, 8'h02);
`endif
    pulse_start();
    send(8'h02, 0); send(8'h02, 0); send(8'h02, 0); send(8'h02, 0); send(8'h02, 1);
    wait_blk();
    expect_blk(1, 1, 3'b001, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    pulse_start();
    chk("restart_overflow", m_ov, 0);
    chk("restart_total", m_tot, 0);
    chk("restart_done", m_dn, 0);
    chk("restart_ready", m_rdy, 1);
    send(8'hFF, 1);
    wait_blk();

    // Start coincident with a valid coefficient discards it
    sel = 1'b0;
    pulse_start();
    send(8'hFF, 0);
    @(negedge clk);
    start = 1'b1; valid = 1'b1; coeff = 8'h03; last = 1'b0;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    chk("collide_total", m_tot, 0);
    chk("collide_t1", m_t1, 0);
    chk("collide_signs", m_sg, 0);
    chk("collide_level_cnt", m_lc, 0);
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(1, 0, 3'b000, 1, 0, 8'd0, 8'h00, 8'h00, 8'h00);
`else
    expect_blk(1, 0, 3'b000, 1, 0, 8'h02, 8'h00, 8'h00, 8'h00);
`endif
    send(8'h02, 1);
    wait_blk();

    // Asynchronous reset mid-block
    pulse_start();
    send(8'h05, 0);
    send(8'h01, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_total", m_tot, 2);
    rst = 1'b0;
    #1;
    chk("async_total", m_tot, 0);
    chk("async_t1", m_t1, 0);
    chk("async_level_cnt", m_lc, 0);
    chk("async_ready", m_rdy, 0);
    chk("async_done", m_dn, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", m_rdy, 0);
`ifdef CAVLC_LEVEL_CODE_EN
    expect_blk(1, 0, 3'b000, 1, 0, 8'd1, 8'h00, 8'h00, 8'h00);
`else
    expect_blk(1, 0, 3'b000, 1, 0, 8'hFE, 8'h00, 8'h00, 8'h00);
`endif
    pulse_start();
    send(8'hFE, 1);
    wait_blk();

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
